// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave in front of a word-organised SRAM.
//
// Ports:
//   HCLK, HRESETn            bus clock, asynchronous active-low reset
//   HSEL, HADDR, HWRITE,     address-phase controls from the master
//   HSIZE, HBURST, HPROT,    (HBURST/HPROT are accepted but not decoded)
//   HTRANS, HREADY
//   HWDATA                   write data, valid in the data phase
//   HRDATA                   read data, valid in the read completion cycle
//   HREADYOUT, HRESP         slave ready and OKAY/ERROR response
//
// Byte, halfword and word accesses are supported. Illegal size, misaligned
// and out-of-range transfers get the two-cycle ERROR response and never
// touch memory. Every OKAY data phase carries WAIT_STATES stall cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no data phase in progress, HREADYOUT=1
// WAIT  | data phase of an OKAY transfer; stalls until cnt reaches 0,
//       | cnt==0 is the completion cycle (with WAIT_STATES=0 that is
//       | the first data-phase cycle)
// ERR1  | first ERROR cycle, HREADYOUT=0
// ERR2  | second ERROR cycle, HREADYOUT=1
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [2:0] WS = 3'(WAIT_STATES);
    localparam logic [HADDR_SIZE:0] MEM_BYTES = (HADDR_SIZE+1)'(MEM_DEPTH) << 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                state, state_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic [AW-1:0]         idx_q;
    logic                  write_q;
    logic [3:0]            mask_q;
    logic [3:0]            mask_in;
    logic [HDATA_SIZE-1:0] rdata_q;
    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    logic accept, xfer_err, complete;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign xfer_err = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (|HADDR[1:0]))
                    | ({1'b0, HADDR} >= MEM_BYTES);
    assign complete = (state == S_WAIT) && (cnt == 3'd0);

    always_comb begin
        case (HSIZE)
            3'd0:    mask_in = 4'b0001 << HADDR[1:0];
            3'd1:    mask_in = 4'b0011 << HADDR[1:0];
            default: mask_in = 4'b1111;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            S_IDLE: ;
            S_WAIT: begin
                HREADYOUT = (cnt == 3'd0);
                if (cnt != 3'd0) cnt_nxt = cnt - 3'd1;
                else             state_nxt = S_IDLE;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = S_ERR2;
            end
            S_ERR2: begin
                HRESP     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // A new address phase can only be presented while HREADY is high,
        // i.e. in IDLE or in the last cycle of WAIT/ERR2; it overrides the
        // return to IDLE so transfers run back-to-back.
        if (accept) begin
            if (xfer_err) begin
                state_nxt = S_ERR1;
            end else begin
                state_nxt = S_WAIT;
                cnt_nxt   = WS;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            mask_q  <= 4'b0000;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                idx_q   <= HADDR[AW+1:2];
                write_q <= HWRITE;
                mask_q  <= mask_in;
            end
            if (complete && !write_q) rdata_q <= mem[idx_q];
        end
    end

    // Read data comes straight from the array during the completion cycle, so
    // a write finishing at the edge that opens this read's data phase is
    // already visible; the register holds it afterwards.
    assign HRDATA = (complete && !write_q) ? mem[idx_q] : rdata_q;

    // Writes only happen in a completion cycle, which reset removes at once,
    // so a write caught by reset is dropped.
    always_ff @(posedge HCLK) begin
        if (complete && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
AHB3-Lite slave with an internal word-organised SRAM. It is the target stage on the bus: it consumes the master-side signals (HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY) and produces HRDATA, HREADYOUT and HRESP. It supports byte, halfword and word accesses, a configurable number of wait states, and the two-cycle ERROR response. It is the DUT the bus driver and monitor attach to.

Parameters:
HADDR_SIZE, 32, address width
HDATA_SIZE, 32, data width; only 32 is supported
MEM_DEPTH, 256, number of HDATA_SIZE-bit words; byte address space is MEM_DEPTH*4
WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..7)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  byte address
HWDATA  in  HDATA_SIZE  write data, valid in the data phase
HRDATA  out  HDATA_SIZE  read data
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size
HBURST  in  3  burst type; accepted, not decoded
HPROT  in  4  protection; accepted, not decoded
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HREADY  in  1  bus ready; ends the previous data phase
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Clock/reset: one clock, HCLK. Reset is asynchronous and active-low on HRESETn.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, all address-phase registers cleared. Memory contents are not reset.
- Address-phase accept: HSEL & HREADY & HTRANS[1] at a rising HCLK edge. The slave registers addr, write, size, and a lane mask.
- IDLE/BUSY transfers, or HSEL=0 with HREADY=1: no transfer is accepted. The next cycle gives HREADYOUT=1, HRESP=0.
- Error check at accept. Any one of these makes the transfer an error:
  - HSIZE > 2
  - misaligned: size 1 with HADDR[0]=1, or size 2 with HADDR[1:0]!=0
  - HADDR >= MEM_DEPTH*4
- Lane mask: size 0 gives 1<<HADDR[1:0]. Size 1 gives 3<<HADDR[1:0]. Size 2 gives 4'hF.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE, on accept of an OKAY transfer: if WAIT_STATES=0, complete in the data phase with HREADYOUT=1. Otherwise go to WAIT with a counter loaded to WAIT_STATES.
  - IDLE, on accept of an error transfer: go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. The counter decrements each cycle. When it reaches 0, HREADYOUT=1 for one cycle (completion), then IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Go to IDLE.
  - A new address phase presented in the completion cycle of WAIT or ERR2 is accepted, because HREADY=1 then. This gives back-to-back operation.
- Write: in the completion cycle, HWDATA byte lanes under the mask are written to mem[addr>>2] at the rising edge that ends the data phase. Unmasked bytes are unchanged. Error transfers never write.
- Read: HRDATA = mem[addr>>2] as a full word, valid in the completion cycle. The master selects lanes.
  - Write then read to the same word back-to-back: the read returns the new data, because the write commits at the edge that starts the read data phase.
  - HRDATA holds its last value outside read completions, including during errors.
- HREADY=0 while the slave is idle (another slave is stalling): no accept, and outputs hold.
- HSEL deasserted during our data phase: the current transfer still completes.
- Reset mid-transfer: immediate return to reset values. A pending write is dropped.

Test Plan:
1. Reset, then word write 0xDEADBEEF to 0x10, then read 0x10 (WAIT_STATES=0) -> HREADYOUT stays 1, HRESP=0, and HRDATA=0xDEADBEEF in the read data phase.
2. After test 1, byte write 0x55 at 0x11 (HWDATA=0x00005500), then word read 0x10 -> 0xDEAD55EF. Then halfword write 0xA5A5 at 0x12 (HWDATA=0xA5A50000) and read -> 0xA5A555EF.
3. WAIT_STATES=2, NONSEQ read then SEQ read pipelined -> each data phase shows exactly 2 cycles of HREADYOUT=0 before HREADYOUT=1. The second address is held by the master until accepted.
4. Halfword at 0x01, word at 0x02, HSIZE=3, and address MEM_DEPTH*4 -> each produces ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). Memory is unchanged when checked by read-back.
5. HTRANS=BUSY and IDLE with HSEL=1, and NONSEQ with HSEL=0 -> HREADYOUT=1, HRESP=0, no memory change.
6. Assert HRESETn=0 asynchronously mid-WAIT of a write -> HREADYOUT=1 and HRESP=0 immediately, without a clock edge. The target word keeps its old value.
